i2c_pad_arb: RTL and testbench

I2C_PAD_ARB -- requirements
Module: i2c_pad_arb

---
 rtl/i2c_pad_arb.sv | 125 ++++++++++++
 tb/tb_i2c_pad_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pad_arb.sv
// Pad-ownership arbiter: hands a shared SCL/SDA pad pair to the native or the APB I2C controller,
// granting only after the bus has been quiet. Optional drain timeout: define I2C_PAD_ARB_TIMEOUT_EN.
module i2c_pad_arb #(
  parameter int unsigned IDLE_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic [1:0] grant_o,
  output logic       sel_o,
  output logic       gate_o,
  output logic       busy_o,
  output logic       to_irq_o
);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("i2c_pad_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t     state_q, state_d;
  logic       scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic       start_det, stop_det, busy_q;
  logic [7:0] quiet_q;
  logic       quiet_full;
  logic       sel_q, last_native_q, win_native, owner_req;
  logic [1:0] grant_q;
  logic       tmo_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {scl_m, scl_s, scl_d} <= '1;
      {sda_m, sda_s, sda_d} <= '1;
    end else begin
      {scl_m, scl_s, scl_d} <= {scl_i, scl_m, scl_s};
      {sda_m, sda_s, sda_d} <= {sda_i, sda_m, sda_s};
    end
  end

  assign start_det = scl_s && scl_d && sda_d && !sda_s;
  assign stop_det  = scl_s && scl_d && !sda_d && sda_s;

  always_ff @(posedge clk_i) begin
    if (rst_i || tmo_hit) busy_q <= 1'b0;
    else if (start_det)   busy_q <= 1'b1;
    else if (stop_det)    busy_q <= 1'b0;
  end

  assign quiet_full = (quiet_q == 8'(IDLE_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) quiet_q <= '0;
    else if (scl_s && sda_s && !busy_q) begin
      if (!quiet_full) quiet_q <= quiet_q + 8'd1;
    end else quiet_q <= '0;
  end

`ifdef I2C_PAD_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        irq_q;

  assign tmo_hit = (state_q == DRAIN) && busy_q && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Counting starts on the first edge spent in DRAIN, so the hit lands TIMEOUT_CYCLES edges after entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != DRAIN || state_d != DRAIN) tmo_cnt_q <= '0;
    else if (busy_q) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= tmo_hit;
  end

  assign to_irq_o = irq_q;
`else
  assign tmo_hit  = 1'b0;
  assign to_irq_o = 1'b0;
`endif

  // In OWN the owner is whatever sel_q was set to on the entering edge.
  assign owner_req = sel_q ? req_i[0] : req_i[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      sel_q         <= 1'b1;
      last_native_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == OWN) begin
        sel_q         <= win_native;
        last_native_q <= win_native;
        grant_q       <= win_native ? 2'b01 : 2'b10;
      end else if (state_d != OWN) begin
        grant_q <= '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    win_native = req_i[0];
    if (req_i == 2'b11) win_native = !last_native_q;
    case (state_q)
      IDLE:    if ((|req_i) && quiet_full) state_d = OWN;
      OWN:     if (!owner_req) state_d = DRAIN;
      DRAIN:   if (!busy_q || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o = grant_q;
    sel_o   = sel_q;
    gate_o  = (state_q != OWN);
    busy_o  = busy_q;
  end

endmodule

// File: tb/tb_i2c_pad_arb.sv
// Scoreboard bench for i2c_pad_arb: every change of {grant,sel,gate,busy,irq} is matched against
// a queued expectation carrying the value and the cycle window in which it must appear.
module tb_i2c_pad_arb;
`ifdef I2C_PAD_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`else
  localparam int unsigned TMO = 65535;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [1:0] grant;
  logic       sel, gate, busy, irq;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [5:0]  val;
    int unsigned lo;
    int unsigned hi;
    int          id;
  } exp_t;

  exp_t sb[$];

  i2c_pad_arb #(.IDLE_CYCLES(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .scl_i(scl), .sda_i(sda),
    .grant_o(grant), .sel_o(sel), .gate_o(gate), .busy_o(busy), .to_irq_o(irq)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    logic [5:0] cur;
    logic [5:0] prev;
    bit         first;
    exp_t       e;
    if (mon_en) begin
      cur = {grant, sel, gate, busy, irq};
      if (!first || cur !== prev) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=%b (grant,sel,gate,busy,irq)", cyc, cur, prev);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (cur !== e.val) begin
            n_bad++;
            $display("FAIL step%0d_value cyc=%0d got=%b required=%b (grant,sel,gate,busy,irq)", e.id, cyc, cur, e.val);
          end
          n_cmp++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_bad++;
            $display("FAIL step%0d_timing got cyc=%0d required cyc %0d..%0d", e.id, cyc, e.lo, e.hi);
          end
        end
      end
      prev  = cur;
      first = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] g, input logic s, input logic gt, input logic b, input logic i,
                      input int unsigned lo, input int unsigned hi, input int id);
    exp_t e;
    e.val = {g, s, gt, b, i};
    e.lo  = lo;
    e.hi  = hi;
    e.id  = id;
    sb.push_back(e);
  endtask

  task automatic settle(input int limit);
    for (int k = 0; k < limit && sb.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL step%0d_pending got=no_change_by_cyc_%0d required=%b", sb[0].id, cyc, sb[0].val);
      sb.delete();
    end
    tick(1);
  endtask

  initial begin
    // Reset values
    tick(2);
    mon_en = 1'b1;
    push(2'b00, 1, 1, 0, 0, cyc, cyc, 0);
    tick(1);
    rst = 1'b0; req = 2'b11;
    push(2'b01, 1, 0, 0, 0, cyc + 17, cyc + 19, 1);
    settle(60);

    // Native hands over to waiting APB on an idle bus; quiet count stays saturated
    tick(3);
    req = 2'b10;
    push(2'b00, 1, 1, 0, 0, cyc + 1, cyc + 1, 2);
    push(2'b10, 0, 0, 0, 0, cyc + 3, cyc + 3, 3);
    settle(20);

    // APB starts a transfer and drops its request: DRAIN holds until STOP
    tick(3);
    sda = 1'b0;
    push(2'b10, 0, 0, 1, 0, cyc + 3, cyc + 3, 4);
    tick(5);
    req = 2'b01;
    push(2'b00, 0, 1, 1, 0, cyc + 1, cyc + 1, 5);
    settle(20);
    tick(20);
    sda = 1'b1;
    push(2'b00, 0, 1, 0, 0, cyc + 3, cyc + 3, 6);
    push(2'b01, 1, 0, 0, 0, cyc + 20, cyc + 20, 7);
    settle(60);

    // Bus START seen in IDLE blocks a native request until STOP plus quiet time
    tick(3);
    req = 2'b00;
    push(2'b00, 1, 1, 0, 0, cyc + 1, cyc + 1, 8);
    tick(3);
    sda = 1'b0;
    push(2'b00, 1, 1, 1, 0, cyc + 3, cyc + 3, 9);
    tick(4);
    req = 2'b01;
    tick(10);
    sda = 1'b1;
    push(2'b00, 1, 1, 0, 0, cyc + 3, cyc + 3, 10);
    push(2'b01, 1, 0, 0, 0, cyc + 20, cyc + 20, 11);
    settle(60);

    // Request withdrawn before quiet time elapses: no grant at all
    tick(3);
    req = 2'b00;
    push(2'b00, 1, 1, 0, 0, cyc + 1, cyc + 1, 12);
    tick(3);
    sda = 1'b0;
    push(2'b00, 1, 1, 1, 0, cyc + 3, cyc + 3, 13);
    tick(5);
    sda = 1'b1;
    push(2'b00, 1, 1, 0, 0, cyc + 3, cyc + 3, 14);
    tick(6);
    req = 2'b10;
    tick(6);
    req = 2'b00;
    tick(30);
    settle(5);

    // Round-robin on simultaneous requests, both directions
    req = 2'b11;
    push(2'b10, 0, 0, 0, 0, cyc + 1, cyc + 1, 15);
    tick(4);
    req = 2'b00;
    push(2'b00, 0, 1, 0, 0, cyc + 1, cyc + 1, 16);
    tick(4);
    req = 2'b11;
    push(2'b01, 1, 0, 0, 0, cyc + 1, cyc + 1, 17);
    settle(20);

    // Reset while native owns drops the grant on that edge
    tick(3);
    rst = 1'b1;
    push(2'b00, 1, 1, 0, 0, cyc + 1, cyc + 1, 18);
    tick(2);
    rst = 1'b0;
    push(2'b01, 1, 0, 0, 0, cyc + 17, cyc + 19, 19);
    settle(60);

    // START with no STOP, then owner drops: timeout if built, otherwise wait for STOP
    tick(3);
    sda = 1'b0;
    push(2'b01, 1, 0, 1, 0, cyc + 3, cyc + 3, 20);
    tick(5);
    req = 2'b00;
    push(2'b00, 1, 1, 1, 0, cyc + 1, cyc + 1, 21);
`ifdef I2C_PAD_ARB_TIMEOUT_EN
    push(2'b00, 1, 1, 0, 1, cyc + 1 + TMO, cyc + 1 + TMO, 22);
    push(2'b00, 1, 1, 0, 0, cyc + 2 + TMO, cyc + 2 + TMO, 23);
    settle(TMO + 40);
    sda = 1'b1;
    tick(25);
`else
    tick(120);
    sda = 1'b1;
    push(2'b00, 1, 1, 0, 0, cyc + 3, cyc + 3, 22);
    settle(20);
`endif
    tick(3);
    settle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
